// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory-access sequencer: memory command codes
// and the controller state type.
package mem_seq_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LDST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter; expired flags the wait cycle whose count
// would reach MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)                               cnt <= '0;
    else if (en && cnt != CW'(MAX_WAIT))   cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt >= CW'(MAX_WAIT - 1));

endmodule

// File: rtl/vDFFE.sv
// Plain enable register: captures d on a rising edge when en is high.
module vDFFE #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk)
    if (en) q <= d;

endmodule

// File: rtl/mem_seq.sv
// Memory-access sequencer: owns PC and IR, serves instruction fetches and
// load/stores over a mem_ready handshake with a wait-state timeout.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0,
  parameter int          MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ldata,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, state_nxt;
  logic   in_cmd, accept, expired, fetch_ok;
  logic   pc_en, ir_en;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] ir_d;

  assign in_cmd   = (state == ST_FETCH) || (state == ST_LDST);
  assign accept   = (state == ST_IDLE) && !pc_load && (ls_req || fetch_req);
  assign fetch_ok = (state == ST_FETCH) && mem_ready;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .clr     (!reset || accept),
    .en      (in_cmd && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!pc_load) begin
          if (ls_req)         state_nxt = ST_LDST;
          else if (fetch_req) state_nxt = ST_FETCH;
        end
      end
      ST_FETCH, ST_LDST: begin
        if (mem_ready)    state_nxt = ST_DONE;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Reset is folded into the enable path so the plain enable registers still clear.
  assign pc_en = !reset || ((state == ST_IDLE) && pc_load) || fetch_ok;
  assign pc_d  = !reset ? ADDR_W'(RESET_PC)
               : (state == ST_IDLE) ? pc_target : pc + ADDR_W'(1);
  assign ir_en = !reset || fetch_ok;
  assign ir_d  = !reset ? '0 : mem_rdata;

  vDFFE #(.n(ADDR_W)) u_pc (.clk(clk), .en(pc_en), .d(pc_d), .q(pc));
  vDFFE #(.n(DATA_W)) u_ir (.clk(clk), .en(ir_en), .d(ir_d), .q(ir));

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_cmd   <= MNONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ldata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
      err  <= (state_nxt == ST_ERR);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (ls_req) begin
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_cmd   <= ls_write ? MWRITE : MREAD;
            end else begin
              mem_addr <= pc;
              mem_cmd  <= MREAD;
            end
          end
        end
        ST_FETCH, ST_LDST: begin
          if (mem_ready || expired) mem_cmd <= MNONE;
          if ((state == ST_LDST) && mem_ready && (mem_cmd == MREAD))
            ldata <= mem_rdata;
        end
        default: mem_cmd <= MNONE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: fetch, waited load, store priority, branch/wrap,
// timeout and reset abort, with hand-computed expectations.
module tb_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, ls_req, ls_write, pc_load, mem_ready;
  logic [8:0]  ls_addr, pc_target;
  logic [15:0] ls_wdata, mem_rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr, pc;
  logic [15:0] mem_wdata, ir, ldata;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  mem_seq dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .ls_req(ls_req),
    .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .pc_load(pc_load), .pc_target(pc_target), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ir(ir), .ldata(ldata), .pc(pc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 0; fetch_req = 0; ls_req = 0; ls_write = 0; pc_load = 0;
    mem_ready = 0; ls_addr = '0; pc_target = '0; ls_wdata = '0; mem_rdata = '0;
    step();
    chk("rst_pc", pc, 0);       chk("rst_ir", ir, 0);
    chk("rst_cmd", mem_cmd, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);   chk("rst_err", err, 0);
    chk("rst_ldata", ldata, 0);
    reset = 1;
    step();

    // 1. zero-wait fetch
    fetch_req = 1; mem_ready = 1; mem_rdata = 16'hD205;
    step();
    chk("f1_cmd", mem_cmd, 1); chk("f1_addr", mem_addr, 0); chk("f1_busy", busy, 1);
    chk("f1_done_early", done, 0);
    step();
    chk("f1_done", done, 1); chk("f1_ir", ir, 16'hD205); chk("f1_pc", pc, 1);
    chk("f1_cmd_off", mem_cmd, 0);
    fetch_req = 0;
    step();
    chk("f1_done_pulse", done, 0); chk("f1_idle", busy, 0);

    // 2. load with 3 wait states
    ls_req = 1; ls_write = 0; ls_addr = 9'h0A3; mem_ready = 0; mem_rdata = 16'h0;
    step();
    chk("ld_cmd1", mem_cmd, 1); chk("ld_addr", mem_addr, 9'h0A3);
    step(); chk("ld_cmd2", mem_cmd, 1);
    step(); chk("ld_cmd3", mem_cmd, 1);
    step(); chk("ld_cmd4", mem_cmd, 1); chk("ld_nodone", done, 0);
    mem_ready = 1; mem_rdata = 16'h1234;
    step();
    chk("ld_done", done, 1); chk("ld_data", ldata, 16'h1234);
    chk("ld_pc", pc, 1); chk("ld_ir", ir, 16'hD205); chk("ld_cmd_off", mem_cmd, 0);
    ls_req = 0;
    step();

    // 3. store wins over simultaneous fetch
    ls_req = 1; ls_write = 1; ls_wdata = 16'hBEEF; ls_addr = 9'h010; fetch_req = 1;
    mem_ready = 1; mem_rdata = 16'hABCD;
    step();
    chk("st_cmd", mem_cmd, 2); chk("st_wdata", mem_wdata, 16'hBEEF);
    chk("st_addr", mem_addr, 9'h010);
    step();
    chk("st_done", done, 1); chk("st_ir", ir, 16'hD205); chk("st_ldata", ldata, 16'h1234);
    chk("st_pc", pc, 1);
    ls_req = 0; ls_write = 0;
    step();
    chk("st_idle_cmd", mem_cmd, 0); chk("st_idle_busy", busy, 0);
    step();
    chk("st_fetch_cmd", mem_cmd, 1); chk("st_fetch_addr", mem_addr, 1);
    step();
    chk("st_fetch_ir", ir, 16'hABCD); chk("st_fetch_pc", pc, 2);
    fetch_req = 0;
    step();

    // 4. branch defers fetch, then pc wraps
    pc_load = 1; pc_target = 9'h1FF; fetch_req = 1; mem_rdata = 16'h5555;
    step();
    chk("br_pc", pc, 9'h1FF); chk("br_cmd", mem_cmd, 0); chk("br_busy", busy, 0);
    pc_load = 0;
    step();
    chk("br_fcmd", mem_cmd, 1); chk("br_faddr", mem_addr, 9'h1FF);
    step();
    chk("br_ir", ir, 16'h5555); chk("br_wrap", pc, 0); chk("br_done", done, 1);
    fetch_req = 0;
    step();

    // 5. timeout after 15 command cycles
    fetch_req = 1; mem_ready = 0;
    step();
    chk("to_cmd1", mem_cmd, 1);
    for (int i = 0; i < 14; i++) step();
    chk("to_cmd15", mem_cmd, 1); chk("to_noerr", err, 0);
    step();
    chk("to_cmd_off", mem_cmd, 0); chk("to_err", err, 1); chk("to_busy", busy, 1);
    fetch_req = 0; ls_req = 1; pc_load = 1; pc_target = 9'h0AA; mem_ready = 1;
    step(); step(); step();
    chk("to_stuck_err", err, 1); chk("to_stuck_cmd", mem_cmd, 0);
    chk("to_no_branch", pc, 0); chk("to_no_done", done, 0);
    ls_req = 0; pc_load = 0; mem_ready = 0;
    reset = 0;
    step();
    chk("to_rst_err", err, 0); chk("to_rst_busy", busy, 0); chk("to_rst_pc", pc, 0);
    reset = 1;
    step();

    // 6. reset aborts an in-flight store
    fetch_req = 1; mem_ready = 1; mem_rdata = 16'h7777;
    step(); step();
    fetch_req = 0;
    step();
    ls_req = 1; ls_write = 0; ls_addr = 9'h020; mem_rdata = 16'h4242;
    step(); step();
    chk("ab_pre_ir", ir, 16'h7777); chk("ab_pre_ldata", ldata, 16'h4242);
    ls_req = 0;
    step();
    ls_req = 1; ls_write = 1; ls_addr = 9'h030; ls_wdata = 16'h9999; mem_ready = 0;
    step();
    chk("ab_cmd", mem_cmd, 2);
    step();
    reset = 0; mem_ready = 1;
    step();
    chk("ab_cmd_off", mem_cmd, 0); chk("ab_busy", busy, 0); chk("ab_done", done, 0);
    chk("ab_ir", ir, 0); chk("ab_ldata", ldata, 0); chk("ab_pc", pc, 0);
    reset = 1; ls_req = 0; ls_write = 0; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_never_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Parametrised memory-access sequencer for the RISC machine. It replaces the fixed one-cycle IF1/IF2 and readM/Mwrite memory states in the CPU controller.
- Owns the PC and the instruction register, and serves instruction fetches and load/store requests from the CPU control FSM.
- Supports variable-latency memory through a mem_ready handshake, with a wait-state timeout, branch loading of the PC, and parametrised data/address widths.

Parameters:
- DATA_W, 16, width of instruction and data words
- ADDR_W, 9, width of memory address and PC
- RESET_PC, 0, PC value after reset
- MAX_WAIT, 15, maximum command cycles without mem_ready before error (1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- fetch_req  in  1  request instruction fetch at pc; held high until done
- ls_req  in  1  request data load/store; held high until done
- ls_write  in  1  1=store, 0=load; valid with ls_req
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- pc_load  in  1  branch: load pc_target into PC
- pc_target  in  ADDR_W  branch target
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes current command this cycle
- mem_cmd  out  2  00 none, 01 MREAD, 10 MWRITE
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- ir  out  DATA_W  instruction register
- ldata  out  DATA_W  last loaded data word
- pc  out  ADDR_W  program counter
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout error

Behaviour:
- Reset (reset==0 at a rising edge), which overrides everything including an in-flight access:
  - state=IDLE, pc=RESET_PC
  - ir, ldata, mem_addr, mem_wdata = 0
  - mem_cmd=00; busy, done, err = 0
  - wait counter = 0
- All outputs are registered.
- States: IDLE, FETCH, LDST, DONE, ERR.
- IDLE:
  - Priority is pc_load > ls_req > fetch_req.
  - pc_load: pc<=pc_target; no request is accepted that cycle.
  - ls_req: latch ls_addr/ls_wdata/ls_write into mem_addr/mem_wdata/command; go to LDST.
  - fetch_req: mem_addr<=pc; go to FETCH.
- FETCH / LDST:
  - mem_cmd is MREAD (fetch, load) or MWRITE (store); mem_addr and mem_wdata are held stable.
  - mem_ready is sampled each cycle.
  - On mem_ready=1:
    - fetch: ir<=mem_rdata; pc<=pc+1, modulo 2^ADDR_W (wraps 2^ADDR_W-1 to 0).
    - load: ldata<=mem_rdata.
    - store: no register update.
    - Then mem_cmd<=00 and go to DONE.
  - On mem_ready=0: increment the wait counter. If the counter reaches MAX_WAIT, mem_cmd<=00, err<=1, go to ERR.
- DONE: done=1 for exactly one cycle, then IDLE. Requesters drop their req in the DONE cycle; a req still high in IDLE is treated as a new request.
- Latency, with a request accepted at edge N:
  - mem_cmd is valid from cycle N+1.
  - With zero wait states (mem_ready=1 in the first command cycle), done is high in cycle N+2.
  - Each wait state adds one cycle.
- ERR: busy=1, err=1, mem_cmd=00. The block stays in ERR until reset; requests and pc_load are ignored.
- pc_load outside IDLE is ignored; the CPU FSM issues branches only between accesses.
- The wait counter clears on every accepted request. It is ceil(log2(MAX_WAIT+1)) bits wide and saturates.

Decomposition:
- Shared package mem_seq_pkg holds:
  - mem_cmd constants MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10 (matching existing `MREAD/`MWRITE)
  - state encoding for IDLE/FETCH/LDST/DONE/ERR
- One sub-module, mem_wait_timer: parametrised by MAX_WAIT, with inputs clr, en and output expired.
- PC and IR use the existing vDFFE enable-register.

Test Plan:
1. Zero-wait fetch: reset, release; fetch_req=1 with mem_ready=1 and mem_rdata=16'hD205 -> mem_cmd=01, mem_addr=0 at cycle 1; done at cycle 2; ir=16'hD205; pc=1.
2. Load with 3 wait states: ls_req=1, ls_write=0, ls_addr=9'h0A3; mem_ready high on the 4th command cycle with mem_rdata=16'h1234 -> mem_cmd=01 held for 4 cycles; ldata=16'h1234; done 5 cycles after acceptance; pc unchanged.
3. Store plus simultaneous requests: ls_req=1, ls_write=1, ls_wdata=16'hBEEF, addr 9'h010, with fetch_req=1 in the same cycle -> store is served first (mem_cmd=10, mem_wdata=16'hBEEF); after done and one IDLE cycle the fetch is issued.
4. Branch and wrap: pc_load=1, pc_target=9'h1FF together with fetch_req=1 -> pc=9'h1FF and the fetch is deferred one cycle; the fetch reads address 9'h1FF, then pc=9'h000.
5. Timeout: fetch with mem_ready held 0 and MAX_WAIT=15 -> after 15 command cycles mem_cmd=00, err=1, busy=1; later requests are ignored; reset clears err and pc=RESET_PC.
6. Reset mid-access: reset=0 during the 2nd wait cycle of a store -> next cycle mem_cmd=00, busy=0, done=0, ir=0, ldata=0; no done pulse is ever generated for the aborted store.
